// File: rtl/draw_scheduler.sv
// Frame sequencer sharing one VGA write port among N drawers: optional clear, then ordered begin_draw/done handshakes.
// Optional full-screen clear is compiled in with `define CLEAR_SCREEN_EN.
module draw_scheduler #(
  parameter int         N        = 3,
  parameter int         TIMEOUT  = 1023,
  parameter logic [2:0] BG_COLOR = 3'b000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           frame_tick,
  input  logic [N-1:0]   en_mask,
  output logic [N-1:0]   begin_draw,
  input  logic [N-1:0]   done,
  input  logic [8*N-1:0] dx,
  input  logic [7*N-1:0] dy,
  input  logic [3*N-1:0] dcolor,
  input  logic [N-1:0]   dplot,
  output logic [7:0]     vga_x,
  output logic [6:0]     vga_y,
  output logic [2:0]     vga_color,
  output logic           vga_plot,
  output logic           busy,
  output logic           frame_done,
  output logic           overrun,
  output logic [N-1:0]   timeout_err
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int WW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [WW-1:0] TMO  = WW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, START, CLEAR, GRANT, WAIT_DONE, RELEASE, NEXT, FRAME_END
  } state_t;

  state_t         state;
  logic [IW-1:0]  idx;
  logic [N-1:0]   mask_r;
  logic [WW-1:0]  wdog;
  logic           pending;
  logic [7:0]     hold_x;
  logic [6:0]     hold_y;
  logic [2:0]     hold_c;
`ifdef CLEAR_SCREEN_EN
  logic [7:0]     cx;
  logic [6:0]     cy;
`endif

  // Drawer buses pass straight through while granted; otherwise coordinates hold their last value.
  always_comb begin
    vga_x     = hold_x;
    vga_y     = hold_y;
    vga_color = hold_c;
    vga_plot  = 1'b0;
    if (state == WAIT_DONE) begin
      vga_x     = dx[8*idx +: 8];
      vga_y     = dy[7*idx +: 7];
      vga_color = dcolor[3*idx +: 3];
      vga_plot  = dplot[idx];
    end
`ifdef CLEAR_SCREEN_EN
    else if (state == CLEAR) begin
      vga_x     = cx;
      vga_y     = cy;
      vga_color = BG_COLOR;
      vga_plot  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      mask_r      <= '0;
      wdog        <= '0;
      pending     <= 1'b0;
      hold_x      <= '0;
      hold_y      <= '0;
      hold_c      <= '0;
      begin_draw  <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= '0;
`ifdef CLEAR_SCREEN_EN
      cx          <= '0;
      cy          <= '0;
`endif
    end else begin
      hold_x     <= vga_x;
      hold_y     <= vga_y;
      hold_c     <= vga_color;
      frame_done <= 1'b0;

      // One tick may queue behind a running frame; any further one is dropped and flagged.
      if (frame_tick && state != IDLE) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (frame_tick || pending) begin
            state   <= START;
            pending <= 1'b0;
            busy    <= 1'b1;
          end
        end
        START: begin
          mask_r <= en_mask;
          idx    <= '0;
`ifdef CLEAR_SCREEN_EN
          cx     <= '0;
          cy     <= '0;
          state  <= CLEAR;
`else
          state  <= GRANT;
`endif
        end
        CLEAR: begin
`ifdef CLEAR_SCREEN_EN
          if (cx == 8'd159) begin
            cx <= '0;
            if (cy == 7'd119) state <= GRANT;
            else              cy    <= cy + 1'b1;
          end else begin
            cx <= cx + 1'b1;
          end
`else
          state <= GRANT;
`endif
        end
        GRANT: begin
          if (mask_r[idx]) begin
            begin_draw <= N'(1) << idx;
            wdog       <= '0;
            state      <= WAIT_DONE;
          end else begin
            state <= NEXT;
          end
        end
        WAIT_DONE: begin
          if (done[idx]) begin
            begin_draw <= '0;
            state      <= RELEASE;
          end else if (wdog == TMO) begin
            begin_draw       <= '0;
            timeout_err[idx] <= 1'b1;
            state            <= NEXT;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        RELEASE: begin
          if (!done[idx]) state <= NEXT;
        end
        NEXT: begin
          if (idx == LAST) begin
            state      <= FRAME_END;
            frame_done <= 1'b1;
          end else begin
            idx   <= idx + 1'b1;
            state <= GRANT;
          end
        end
        FRAME_END: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
